id_stage_regs: RTL

Parametrised instruction-decode stage for the 5-stage MIPS32 pipeline. It contains:

- the register bank, with write-before-read bypass;
- an immediate extender with sign or zero mode;
- load-use hazard detection;
- the ID/EX pipeline register, with hold, flush and bubble insertion.

It sits between the IF/ID register and the EX stage and takes write-back from WB.

---
 rtl/id_stage_regs.sv | 102 ++++++++++
 1 files changed

// File: rtl/id_stage_regs.sv
// MIPS32 instruction-decode stage: register bank with write-back bypass,
// immediate extender, load-use hazard detection and the ID/EX pipeline register.
module id_stage_regs #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       id_instr,
  input  logic              id_valid,
  input  logic              id_uses_rt,
  input  logic              id_zext,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_mem_read,
  input  logic [AW-1:0]     ex_rt_in,
  input  logic              hold,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_dr1,
  output logic [DATA_W-1:0] ex_dr2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [AW-1:0]     ex_rs,
  output logic [AW-1:0]     ex_rt,
  output logic [AW-1:0]     ex_rd
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [AW-1:0]     rs, rt, rd;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] rd1, rd2, imm_ext;
  logic              wb_live;
  logic              hazard;
  logic              unused_instr_bits;

  // Register fields are truncated to AW bits when NREGS < 32.
  assign rs    = id_instr[21 +: AW];
  assign rt    = id_instr[16 +: AW];
  assign rd    = id_instr[11 +: AW];
  assign imm16 = id_instr[15:0];
  assign unused_instr_bits = ^id_instr;

  assign wb_live = wb_we && (wb_addr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_live) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rd1 = (rs == '0) ? '0 : regs[rs];
    rd2 = (rt == '0) ? '0 : regs[rt];
    if ((BYPASS != 0) && wb_live && (wb_addr == rs)) rd1 = wb_data;
    if ((BYPASS != 0) && wb_live && (wb_addr == rt)) rd2 = wb_data;
  end

  assign imm_ext = id_zext ? DATA_W'(imm16) : DATA_W'($signed(imm16));

  // A load in EX whose destination feeds this instruction forces one bubble;
  // a taken branch kills the decode anyway, so it never stalls.
  assign hazard = id_valid && ex_mem_read && ex_valid && (ex_rt_in != '0) &&
                  ((ex_rt_in == rs) || (id_uses_rt && (ex_rt_in == rt)));
  assign stall  = hazard && !flush;

  // ex_valid qualifies every other ex_* field: when low the stage holds a
  // bubble and downstream logic must ignore the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_dr1   <= '0;
      ex_dr2   <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
    end else if (flush || (!hold && stall)) begin
      ex_valid <= 1'b0;
      ex_dr1   <= '0;
      ex_dr2   <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
    end else if (!hold) begin
      ex_valid <= id_valid;
      ex_dr1   <= rd1;
      ex_dr2   <= rd2;
      ex_imm   <= imm_ext;
      ex_rs    <= rs;
      ex_rt    <= rt;
      ex_rd    <= rd;
    end
  end

endmodule
